// File: rtl/stack_ret.sv
// Return-address stack with combinational top-of-stack and push/pop/replace.
// Define STACK_ERR_FLAGS_EN to build the sticky ovf/udf error registers.
module stack_ret #(
    parameter int AW    = 10,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wesp,
    input  logic                       push,
    input  logic                       pop,
    input  logic [AW-1:0]              d_in,
    output logic [AW-1:0]              d_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
    output logic                       udf
);
    localparam int IW  = $clog2(DEPTH);
    localparam int SPW = IW + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    logic [AW-1:0]  mem_q [DEPTH];
    logic [SPW-1:0] sp_q, sp_d;
    logic [SPW-1:0] sp_m1;
    logic [IW-1:0]  top_idx;
    logic [IW-1:0]  wr_idx;
    logic           empty_w, full_w;
    logic           do_push, do_pop, do_repl, do_wr;
    logic           set_ovf, set_udf;

    assign empty_w = (sp_q == '0);
    assign full_w  = (sp_q == SP_FULL);
    assign sp_m1   = sp_q - 1'b1;
    assign top_idx = sp_m1[IW-1:0];

    // push+pop on a non-empty stack rewrites the top in place
    assign do_repl = wesp & push & pop & ~empty_w;
    assign do_push = wesp & push & (~pop | empty_w) & ~full_w;
    assign do_pop  = wesp & pop & ~push & ~empty_w;
    assign set_ovf = wesp & push & ~pop & full_w;
    assign set_udf = wesp & pop & ~push & empty_w;
    assign do_wr   = do_push | do_repl;
    assign wr_idx  = do_repl ? top_idx : sp_q[IW-1:0];

    always_comb begin
        sp_d = sp_q;
        if (do_push) begin
            sp_d = sp_q + 1'b1;
        end else if (do_pop) begin
            sp_d = sp_m1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // array contents are never visible while empty, so no reset needed
    always_ff @(posedge clk) begin
        if (do_wr && !reset) begin
            mem_q[wr_idx] <= d_in;
        end
    end

`ifdef STACK_ERR_FLAGS_EN
    logic ovf_q, udf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | set_ovf;
            udf_q <= udf_q | set_udf;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`else
    logic unused_flags;
    assign unused_flags = set_ovf | set_udf;
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

    assign d_out = empty_w ? '0 : mem_q[top_idx];
    assign count = sp_q;
    assign empty = empty_w;
    assign full  = full_w;
endmodule

// File: tb/tb_stack_ret.sv
// Table-driven and randomized checks of stack_ret against a queue model.
module tb_stack_ret;
    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef STACK_ERR_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, wesp, push, pop;
    logic [AW-1:0] d_in, d_out;
    logic [CW-1:0] count;
    logic          empty, full, ovf, udf;

    int n_cmp = 0;
    int n_err = 0;

    stack_ret #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wesp(wesp), .push(push), .pop(pop),
        .d_in(d_in), .d_out(d_out), .count(count), .empty(empty),
        .full(full), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst, we, pu, po;
        logic [AW-1:0] din;
        int            cnt;
        logic [AW-1:0] dout;
        logic          ovf, udf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic w, logic pu, logic po,
                                int din, int cnt, int dout,
                                logic o, logic u);
        vec_t v;
        v.rst = r; v.we = w; v.pu = pu; v.po = po;
        v.din = AW'(din); v.cnt = cnt; v.dout = AW'(dout);
        v.ovf = o; v.udf = u;
        return v;
    endfunction

    task automatic check_all(string name, int cnt, logic [AW-1:0] dout,
                             logic o, logic u);
        logic [AW+CW+3:0] act, exp;
        logic             eo, eu;
        eo  = o & FLAGS_EN;
        eu  = u & FLAGS_EN;
        act = {count, d_out, empty, full, ovf, udf};
        exp = {CW'(cnt), dout, cnt == 0, cnt == DEPTH, eo, eu};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got cnt=%0d dout=%h e=%b f=%b o=%b u=%b want cnt=%0d dout=%h e=%b f=%b o=%b u=%b",
                     name, count, d_out, empty, full, ovf, udf,
                     cnt, dout, cnt == 0, cnt == DEPTH, eo, eu);
        end
    endtask

    task automatic drive(logic r, logic w, logic pu, logic po, int din);
        reset = r; wesp = w; push = pu; pop = po; d_in = AW'(din);
        @(posedge clk);
        #1;
        reset = 1'b0; wesp = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    // reference model
    int   q[$];
    logic m_ovf, m_udf;

    task automatic model(logic r, logic w, logic pu, logic po, int din);
        if (r) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (w) begin
            if (pu && po) begin
                if (q.size() > 0) q[q.size()-1] = din;
                else q.push_back(din);
            end else if (pu) begin
                if (q.size() < DEPTH) q.push_back(din);
                else m_ovf = 1'b1;
            end else if (po) begin
                if (q.size() > 0) void'(q.pop_back());
                else m_udf = 1'b1;
            end
        end
    endtask

    initial begin
        reset = 1'b1; wesp = 1'b0; push = 1'b0; pop = 1'b0; d_in = '0;

        //          rst we pu po din    cnt dout   o  u
        tbl.push_back(mk(1, 0, 0, 0, 'h000, 0, 'h000, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 'h005, 1, 'h005, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 'h00A, 2, 'h00A, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 'h0FF, 3, 'h0FF, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 'h000, 2, 'h00A, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 'h000, 1, 'h005, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 'h000, 0, 'h000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 'h000, 0, 'h000, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 'h001, 1, 'h001, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 'h002, 2, 'h002, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 'h003, 3, 'h003, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 'h004, 4, 'h004, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 'h005, 4, 'h004, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 'h000, 0, 'h000, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 'h000, 0, 'h000, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 'h010, 1, 'h010, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 'h020, 2, 'h020, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 'h123, 2, 'h123, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 'h030, 3, 'h030, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 'h040, 4, 'h040, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 'h155, 4, 'h155, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 'h000, 3, 'h030, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 'h000, 0, 'h000, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 'h0AB, 1, 'h0AB, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 'h002, 2, 'h002, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 'h003, 3, 'h003, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 'h3FF, 3, 'h003, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 'h000, 3, 'h003, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 'h111, 3, 'h003, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 'h222, 0, 'h000, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 'h077, 1, 'h077, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 'h000, 0, 'h000, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].we, tbl[i].pu, tbl[i].po, int'(tbl[i].din));
            check_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].dout,
                      tbl[i].ovf, tbl[i].udf);
        end

        // return address must be visible during the pop cycle itself
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 'h111);
        drive(0, 1, 1, 0, 'h222);
        reset = 1'b0; wesp = 1'b1; push = 1'b0; pop = 1'b1;
        #1;
        check_all("pop_same_cycle", 2, 'h222, 0, 0);
        @(posedge clk);
        #1;
        wesp = 1'b0; pop = 1'b0;
        check_all("pop_after", 1, 'h111, 0, 0);

        // randomized run against the queue model
        drive(1, 0, 0, 0, 0);
        model(1, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            logic r, w, pu, po;
            int   din;
            r   = ($urandom_range(0, 49) == 0);
            w   = ($urandom_range(0, 5) != 0);
            pu  = $urandom_range(0, 1);
            po  = $urandom_range(0, 1);
            din = $urandom_range(0, (1 << AW) - 1);
            drive(r, w, pu, po, din);
            model(r, w, pu, po, din);
            check_all($sformatf("rnd%0d", i), q.size(),
                      q.size() > 0 ? AW'(q[q.size()-1]) : '0,
                      m_ovf, m_udf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/stack_ret.md
STACK_RET -- requirements
Module: stack_ret

Interface
REQ-001 Parameter: AW, default 10, return-address width in bits (PC width).
REQ-002 Parameter: DEPTH, default 16, number of stack entries; power of two, minimum 2.
REQ-003 The block SHALL have the following ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- wesp  input  1  stack write enable from the control unit; push/pop act only when high.
- push  input  1  push request (call).
- pop  input  1  pop request (return).
- d_in  input  AW  return address to push (PC+1).
- d_out  output  AW  current top-of-stack, combinational.
- count  output  log2(DEPTH)+1  number of valid entries.
- empty  output  1  high when count==0.
- full  output  1  high when count==DEPTH.
- ovf  output  1  sticky overflow flag.
- udf  output  1  sticky underflow flag.

Function
REQ-004 Storage: DEPTH x AW register array plus stack pointer sp (log2(DEPTH)+1 bits); sp equals count; entry sp-1 is top.
REQ-005 d_out SHALL equal mem[sp-1] combinationally, and 0 when empty, so a pop cycle's PC mux sees the return address in the same cycle.
REQ-006 wesp=0: no state change regardless of push/pop.
REQ-007 Push (wesp=1, push=1, pop=0, not full): mem[sp]<=d_in, sp<=sp+1 at the next edge.
REQ-008 Pop (wesp=1, pop=1, push=0, not empty): sp<=sp-1 at the next edge; the vacated entry keeps its content.
REQ-009 Push when full: mem and sp unchanged; ovf<=1.
REQ-010 Pop when empty: sp unchanged; d_out=0; udf<=1.
REQ-011 push=1 and pop=1 with wesp=1, not empty: replace top, mem[sp-1]<=d_in, sp unchanged, including when full, with no ovf.
REQ-012 push=1 and pop=1 with wesp=1, empty: behaves as a push (REQ-007); no udf.
REQ-013 wesp=1 with push=0 and pop=0: no state change.
REQ-014 empty, full and count SHALL be derived from sp only, registered state with no combinational path from inputs.
REQ-015 Arithmetic on sp SHALL never wrap: sp stays within 0..DEPTH under all input sequences.

Reset
REQ-016 reset=1 at a rising edge SHALL set sp=0, ovf=0 and udf=0, taking priority over any simultaneous push/pop.
REQ-017 After reset: count=0, empty=1, full=0, d_out=0; array contents are don't-care and are never observable.
REQ-018 Reset asserted mid-sequence SHALL discard all entries; the first push after reset lands in mem[0].

Configuration
REQ-019 Macro STACK_ERR_FLAGS_EN: when defined, ovf/udf SHALL be sticky registers set per REQ-009/REQ-010 and cleared only by reset.
REQ-020 Without STACK_ERR_FLAGS_EN, ovf and udf SHALL be tied to 0 and their registers omitted; all other behaviour SHALL be identical.

Verification (DEPTH=4, AW=10, macro defined unless stated)
REQ-021 The bench SHALL cover: reset, then push 0x005, 0x00A, 0x0FF -> count=3, d_out=0x0FF; three pops -> d_out sequence 0x0FF, 0x00A, 0x005, then empty=1, d_out=0.
REQ-022 The bench SHALL cover: push five values 0x001..0x005 -> full=1 after the fourth, ovf=1 after the fifth, d_out=0x004, count=4.
REQ-023 The bench SHALL cover: pop when empty -> udf=1, count=0; udf stays 1 through later pushes until reset.
REQ-024 The bench SHALL cover: with count=2 and top 0x020, push=pop=wesp=1 with d_in=0x123 -> count=2, d_out=0x123; repeat the same when full -> ovf stays 0.
REQ-025 The bench SHALL cover: push=1, wesp=0 -> count unchanged; reset pulsed with count=3 while push=1 -> count=0, empty=1.
REQ-026 The bench SHALL cover: without STACK_ERR_FLAGS_EN, rerun REQ-022/REQ-023 -> ovf=udf=0 throughout, all other outputs identical.
